// File: rtl/datapath_mc.sv
// Multi-cycle integer datapath: single-cycle ALU/branch/jump, with loads and stores
// sequenced through a RUN -> MEM_REQ -> MEM_WAIT handshake on a simple data bus.
module datapath_mc #(
   parameter int unsigned   XLEN     = 32,
   parameter int unsigned   NREG     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [4:0]        rd,
   input  logic [2:0]        funct3,
   input  logic [3:0]        alu_ctrl,
   input  logic [XLEN-1:0]   imm_out,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              alu_src,
   input  logic              is_branch,
   input  logic              is_jal,
   input  logic              is_jalr,
   input  logic [1:0]        op1_sel,
   input  logic [1:0]        wb_sel,
   output logic [XLEN-1:0]   imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN/8-1:0] dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_ack,
   output logic              misaligned
);

   localparam int unsigned BEW  = XLEN / 8;
   localparam int unsigned OFFW = $clog2(BEW);
   localparam int unsigned SHW  = $clog2(XLEN);
   localparam int unsigned IDXW = $clog2(NREG);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   localparam logic [1:0] OP1_RS1  = 2'd0;
   localparam logic [1:0] OP1_PC   = 2'd1;
   localparam logic [1:0] OP1_ZERO = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef enum logic [1:0] {RUN, MEM_REQ, MEM_WAIT} state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   pc_current;
   logic [XLEN-1:0]   regs [0:NREG-1];

   logic [XLEN-1:0]   rs1_data, rs2_data, op1, op2, alu_res;
   logic [SHW-1:0]    shamt;
   logic              rd_ok, br_taken;
   logic [XLEN-1:0]   pc_plus4, next_pc, pc_nxt;
   logic [XLEN-1:0]   mem_addr, mem_wdata, ld_shift, load_data, wb_data;
   logic [BEW-1:0]    mem_be;
   logic [7:0]        size_mask;
   logic              mem_op, mem_misal, mem_illegal, mem_bad;
   logic              retire, issue, mem_err, ack_done, rf_we, pc_we;

   assign imem_addr = pc_current;
   assign instr     = imem_rdata;

   // Register file read: x0 and indices beyond NREG read as zero
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1 != 5'd0 && 32'(rs1) < NREG) rs1_data = regs[rs1[IDXW-1:0]];
      if (rs2 != 5'd0 && 32'(rs2) < NREG) rs2_data = regs[rs2[IDXW-1:0]];
      rd_ok = (rd != 5'd0) && (32'(rd) < NREG);
   end

   always_comb begin
      op1 = rs1_data;
      case (op1_sel)
         OP1_RS1:  op1 = rs1_data;
         OP1_PC:   op1 = pc_current;
         OP1_ZERO: op1 = '0;
         default:  op1 = rs1_data;
      endcase
      op2   = alu_src ? imm_out : rs2_data;
      shamt = op2[SHW-1:0];
      case (alu_ctrl)
         ALU_ADD:  alu_res = op1 + op2;
         ALU_SUB:  alu_res = op1 - op2;
         ALU_AND:  alu_res = op1 & op2;
         ALU_OR:   alu_res = op1 | op2;
         ALU_XOR:  alu_res = op1 ^ op2;
         ALU_SLL:  alu_res = op1 << shamt;
         ALU_SRL:  alu_res = op1 >> shamt;
         ALU_SRA:  alu_res = XLEN'($signed(op1) >>> shamt);
         ALU_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
         ALU_SLTU: alu_res = XLEN'(op1 < op2);
         ALU_PASS: alu_res = op2;
         default:  alu_res = '0;
      endcase
   end

   // Branch condition and next-PC selection
   always_comb begin
      case (funct3)
         3'b000:  br_taken = (rs1_data == rs2_data);
         3'b001:  br_taken = (rs1_data != rs2_data);
         3'b100:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
         3'b101:  br_taken = !($signed(rs1_data) < $signed(rs2_data));
         3'b110:  br_taken = (rs1_data < rs2_data);
         3'b111:  br_taken = !(rs1_data < rs2_data);
         default: br_taken = 1'b0;
      endcase
      pc_plus4 = pc_current + XLEN'(4);
      if (is_jalr)                    next_pc = (rs1_data + imm_out) & ~XLEN'(1);
      else if (is_jal)                next_pc = pc_current + imm_out;
      else if (is_branch && br_taken) next_pc = pc_current + imm_out;
      else                            next_pc = pc_plus4;
   end

   // Store-side address check, lane replication and byte enables
   always_comb begin
      mem_op   = mem_read | mem_write;
      mem_addr = rs1_data + imm_out;
      case (funct3[1:0])
         2'b01:   mem_misal = mem_addr[0];
         2'b10:   mem_misal = |mem_addr[1:0];
         2'b11:   mem_misal = |mem_addr[2:0];
         default: mem_misal = 1'b0;
      endcase
      mem_illegal = (funct3 == 3'b111) || (funct3[1:0] == 2'b11 && XLEN == 32);
      mem_bad     = mem_misal | mem_illegal;
      case (funct3[1:0])
         2'b00: begin size_mask = 8'h01; mem_wdata = {BEW{rs2_data[7:0]}}; end
         2'b01: begin size_mask = 8'h03; mem_wdata = {(BEW/2){rs2_data[15:0]}}; end
         2'b10: begin size_mask = 8'h0F; mem_wdata = {(XLEN/32){rs2_data[31:0]}}; end
         default: begin size_mask = 8'hFF; mem_wdata = rs2_data; end
      endcase
      mem_be = BEW'(16'(size_mask) << mem_addr[OFFW-1:0]);
   end

   // Load lane extraction uses the held access address; controls are stable while stalled
   always_comb begin
      ld_shift = dmem_rdata >> {dmem_addr[OFFW-1:0], 3'b000};
      case (funct3)
         3'b000:  load_data = XLEN'($signed(ld_shift[7:0]));
         3'b100:  load_data = XLEN'(ld_shift[7:0]);
         3'b001:  load_data = XLEN'($signed(ld_shift[15:0]));
         3'b101:  load_data = XLEN'(ld_shift[15:0]);
         3'b010:  load_data = XLEN'($signed(ld_shift[31:0]));
         3'b110:  load_data = XLEN'(ld_shift[31:0]);
         default: load_data = ld_shift;
      endcase
      case (wb_sel)
         WB_ALU:  wb_data = alu_res;
         WB_MEM:  wb_data = load_data;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      retire    = 1'b0;
      issue     = 1'b0;
      mem_err   = 1'b0;
      ack_done  = 1'b0;
      case (state)
         RUN: begin
            if (mem_op && !mem_bad) begin
               stall     = 1'b1;
               issue     = 1'b1;
               state_nxt = MEM_REQ;
            end else if (mem_op) begin
               mem_err = 1'b1;
            end else begin
               retire = 1'b1;
            end
         end
         MEM_REQ: begin
            stall     = 1'b1;
            state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            stall = 1'b1;
            if (dmem_ack) begin
               ack_done  = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
      rf_we  = (retire | ack_done) & reg_write & rd_ok;
      pc_we  = retire | mem_err | ack_done;
      pc_nxt = retire ? next_pc : pc_plus4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_current <= RESET_PC;
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         misaligned <= 1'b0;
      end else begin
         if (pc_we) pc_current <= pc_nxt;
         if (rf_we) regs[rd[IDXW-1:0]] <= wb_data;
         if (mem_err) misaligned <= 1'b1;
         if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= mem_addr;
            dmem_be    <= mem_be;
            dmem_wdata <= mem_wdata;
         end
         if (ack_done) dmem_req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_datapath_mc.sv
// Scoreboard bench for datapath_mc: a 32-bit/32-reg and a 64-bit/16-reg instance share
// stimulus; one is selected for observation per phase.
module tb_datapath_mc;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRA = 4'd7;
   localparam logic [1:0] OP1_RS1 = 2'd0;
   localparam logic [1:0] OP1_PC  = 2'd1;
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [63:0] RST64  = 64'h100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic [3:0]  alu_ctrl;
   logic [63:0] imm, rdata;
   logic        reg_write, mem_read, mem_write, alu_src, is_branch, is_jal, is_jalr, ack;
   logic [1:0]  op1_sel, wb_sel;
   logic [31:0] imem_rdata;

   logic [31:0] imem_addr32, instr32, addr32, wdata32;
   logic [3:0]  be32;
   logic        stall32, req32, we32, mis32;
   logic [63:0] imem_addr64, addr64, wdata64;
   logic [31:0] instr64;
   logic [7:0]  be64;
   logic        stall64, req64, we64, mis64;

   logic        use64;
   logic [63:0] o_addr, o_wdata, o_imem;
   logic [31:0] o_instr;
   logic [7:0]  o_be;
   logic        o_stall, o_req, o_we, o_mis;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   string       tag_q[$];
   logic [63:0] last_wdata;
   logic [63:0] pc0;

   datapath_mc #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) u_dut32 (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3),
      .alu_ctrl(alu_ctrl), .imm_out(imm[31:0]), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .alu_src(alu_src), .is_branch(is_branch), .is_jal(is_jal),
      .is_jalr(is_jalr), .op1_sel(op1_sel), .wb_sel(wb_sel), .imem_addr(imem_addr32),
      .imem_rdata(imem_rdata), .instr(instr32), .stall(stall32), .dmem_req(req32),
      .dmem_we(we32), .dmem_addr(addr32), .dmem_be(be32), .dmem_wdata(wdata32),
      .dmem_rdata(rdata[31:0]), .dmem_ack(ack), .misaligned(mis32));

   datapath_mc #(.XLEN(64), .NREG(16), .RESET_PC(RST64)) u_dut64 (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3),
      .alu_ctrl(alu_ctrl), .imm_out(imm), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .alu_src(alu_src), .is_branch(is_branch), .is_jal(is_jal),
      .is_jalr(is_jalr), .op1_sel(op1_sel), .wb_sel(wb_sel), .imem_addr(imem_addr64),
      .imem_rdata(imem_rdata), .instr(instr64), .stall(stall64), .dmem_req(req64),
      .dmem_we(we64), .dmem_addr(addr64), .dmem_be(be64), .dmem_wdata(wdata64),
      .dmem_rdata(rdata), .dmem_ack(ack), .misaligned(mis64));

   always #5 clk = ~clk;

   always_comb begin
      if (use64) begin
         o_addr = addr64; o_wdata = wdata64; o_be = be64; o_imem = imem_addr64;
         o_instr = instr64; o_stall = stall64; o_req = req64; o_we = we64; o_mis = mis64;
      end else begin
         o_addr = 64'(addr32); o_wdata = 64'(wdata32); o_be = 8'(be32); o_imem = 64'(imem_addr32);
         o_instr = instr32; o_stall = stall32; o_req = req32; o_we = we32; o_mis = mis32;
      end
   end

   function automatic logic [63:0] pc_now();
      if (use64) return u_dut64.pc_current;
      return 64'(u_dut32.pc_current);
   endfunction

   function automatic logic [63:0] get_reg(input int i);
      if (use64) return u_dut64.regs[4'(i)];
      return 64'(u_dut32.regs[5'(i)]);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [63:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic sb_pop(input logic [63:0] got);
      if (exp_q.size() == 0) begin
         check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
         return;
      end
      check_eq(tag_q.pop_front(), got, exp_q.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; rd = 0; funct3 = 0; alu_ctrl = ALU_ADD; imm = 0;
      reg_write = 0; mem_read = 0; mem_write = 0; alu_src = 0;
      is_branch = 0; is_jal = 0; is_jalr = 0; op1_sel = OP1_RS1; wb_sel = WB_ALU;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic alu_op(input string tag, input logic [4:0] d, s1, s2, input logic [3:0] alu,
                         input logic [63:0] im, input logic asrc, input logic [1:0] op1,
                         input logic [63:0] exp);
      idle();
      rd = d; rs1 = s1; rs2 = s2; alu_ctrl = alu; imm = im; alu_src = asrc;
      op1_sel = op1; reg_write = 1'b1;
      pc0 = pc_now();
      sb_push(tag, exp);
      #1 check_eq({tag, "_stall"}, 64'(o_stall), 64'd0);
      tick();
      sb_pop(get_reg(int'(d)));
      check_eq({tag, "_pc"}, pc_now(), pc0 + 64'd4);
   endtask

   task automatic br_op(input string tag, input logic [2:0] f3, input logic [4:0] s1, s2,
                        input logic [63:0] im, input logic taken);
      idle();
      is_branch = 1'b1; funct3 = f3; rs1 = s1; rs2 = s2; imm = im;
      pc0 = pc_now();
      sb_push(tag, taken ? pc0 + im : pc0 + 64'd4);
      tick();
      sb_pop(pc_now());
   endtask

   task automatic mem_op(input logic store, input logic [2:0] f3, input logic [4:0] d, s1, s2,
                         input logic [63:0] im);
      idle();
      funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im; alu_src = 1'b1;
      if (store) mem_write = 1'b1;
      else begin mem_read = 1'b1; reg_write = 1'b1; wb_sel = WB_MEM; end
   endtask

   // Sequences one legal access; the caller has pushed addr, be (and wdata for stores)
   task automatic mem_access(input int n_wait, input logic [63:0] rd_data,
                             input logic store, input logic early_ack);
      int reqs;
      reqs = 0;
      #1 check_eq("stall_run", 64'(o_stall), 64'd1);
      pc0 = pc_now();
      tick();
      if (o_req) reqs++;
      sb_pop(o_addr);
      sb_pop(64'(o_be));
      if (store) sb_pop(o_wdata);
      check_eq("dmem_we", 64'(o_we), 64'(store));
      last_wdata = o_wdata;
      if (early_ack) begin ack = 1'b1; rdata = 64'hDEAD; end
      tick();
      ack = 1'b0;
      for (int i = 0; i < n_wait; i++) begin
         if (o_req) reqs++;
         tick();
      end
      check_eq("pc_hold", pc_now(), pc0);
      check_eq("stall_wait", 64'(o_stall), 64'd1);
      ack = 1'b1;
      rdata = rd_data;
      if (o_req) reqs++;
      tick();
      ack = 1'b0;
      check_eq("req_cycles", 64'(reqs), 64'(n_wait + 2));
      check_eq("req_drop", 64'(o_req), 64'd0);
      check_eq("pc_ack", pc_now(), pc0 + 64'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      imem_rdata = NOP;
      ack = 1'b0;
      rdata = '0;
      use64 = 1'b0;
      do_reset();

      // 32-bit instance
      check_eq("rst_pc", pc_now(), 64'd0);
      check_eq("rst_imem", o_imem, 64'd0);
      check_eq("instr", 64'(o_instr), 64'(NOP));
      check_eq("rst_req", 64'(o_req), 64'd0);
      check_eq("rst_be", 64'(o_be), 64'd0);
      check_eq("rst_mis", 64'(o_mis), 64'd0);

      alu_op("addi_x5", 5, 0, 0, ALU_ADD, 64'd123, 1'b1, OP1_RS1, 64'd123);
      alu_op("slli_x10", 10, 5, 0, ALU_SLL, 64'd2, 1'b1, OP1_RS1, 64'd492);

      mem_op(1'b1, 3'b010, 0, 0, 5, 64'h10);
      sb_push("sw_addr", 64'h10); sb_push("sw_be", 64'hF); sb_push("sw_wdata", 64'd123);
      mem_access(3, 64'h0, 1'b1, 1'b1);

      mem_op(1'b0, 3'b000, 6, 0, 0, 64'h10);
      sb_push("lb_addr", 64'h10); sb_push("lb_be", 64'h1); sb_push("lb_data", 64'hFFFF_FF80);
      mem_access(1, 64'h80, 1'b0, 1'b0);
      sb_pop(get_reg(6));

      mem_op(1'b0, 3'b100, 7, 0, 0, 64'h10);
      sb_push("lbu_addr", 64'h10); sb_push("lbu_be", 64'h1); sb_push("lbu_data", 64'h80);
      mem_access(2, 64'h80, 1'b0, 1'b0);
      sb_pop(get_reg(7));

      alu_op("addi_x8", 8, 0, 0, ALU_ADD, 64'hCCDD, 1'b1, OP1_RS1, 64'hCCDD);
      mem_op(1'b1, 3'b001, 0, 0, 8, 64'h12);
      sb_push("sh_addr", 64'h12); sb_push("sh_be", 64'hC); sb_push("sh_wdata", 64'hCCDD_CCDD);
      mem_access(0, 64'hAABB_CCDD, 1'b1, 1'b0);

      mem_op(1'b0, 3'b001, 12, 0, 0, 64'h12);
      sb_push("lh_addr", 64'h12); sb_push("lh_be", 64'hC); sb_push("lh_data", 64'hFFFF_AABB);
      mem_access(1, 64'hAABB_CCDD, 1'b0, 1'b0);
      sb_pop(get_reg(12));

      mem_op(1'b0, 3'b010, 9, 0, 0, 64'h11);
      pc0 = pc_now();
      #1 check_eq("lw_mis_stall", 64'(o_stall), 64'd0);
      tick();
      check_eq("lw_mis_req", 64'(o_req), 64'd0);
      check_eq("lw_mis_flag", 64'(o_mis), 64'd1);
      check_eq("lw_mis_pc", pc_now(), pc0 + 64'd4);
      check_eq("lw_mis_rd", get_reg(9), 64'd0);

      idle();
      rd = 2; rs1 = 5; imm = 64'd8; is_jalr = 1'b1; reg_write = 1'b1; wb_sel = WB_PC4;
      pc0 = pc_now();
      sb_push("jalr_link", pc0 + 64'd4); sb_push("jalr_pc", 64'd130);
      tick();
      sb_pop(get_reg(2));
      sb_pop(pc_now());

      br_op("beq_taken", 3'b000, 5, 5, 64'd16, 1'b1);
      br_op("bne_not", 3'b001, 5, 5, 64'd16, 1'b0);
      br_op("blt_wrap", 3'b100, 6, 5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
      br_op("bltu_not", 3'b110, 6, 5, 64'd16, 1'b0);
      br_op("f3_010_not", 3'b010, 5, 5, 64'd16, 1'b0);

      alu_op("sra_x11", 11, 6, 0, ALU_SRA, 64'd4, 1'b1, OP1_RS1, 64'hFFFF_FFF8);
      alu_op("sub_x13", 13, 5, 10, ALU_SUB, 64'd0, 1'b0, OP1_RS1, 64'hFFFF_FE8F);
      alu_op("auipc_x14", 14, 0, 0, ALU_ADD, 64'h1000, 1'b1, OP1_PC, pc_now() + 64'h1000);
      alu_op("x0_drop", 0, 0, 0, ALU_ADD, 64'd5, 1'b1, OP1_RS1, 64'd0);
      check_eq("mis_sticky", 64'(o_mis), 64'd1);

      // 64-bit, 16-register instance
      use64 = 1'b1;
      do_reset();
      check_eq("rst64_pc", pc_now(), RST64);
      check_eq("rst64_imem", o_imem, RST64);
      check_eq("rst64_mis", 64'(o_mis), 64'd0);

      idle();
      rd = 20; imm = 64'd77; alu_src = 1'b1; reg_write = 1'b1;
      tick();
      check_eq("x20_alias", get_reg(4), 64'd0);
      alu_op("x20_read", 5, 20, 0, ALU_ADD, 64'd0, 1'b1, OP1_RS1, 64'd0);

      alu_op("addi_x3", 3, 0, 0, ALU_ADD, 64'h8000_0000_0000_0001, 1'b1, OP1_RS1,
             64'h8000_0000_0000_0001);

      mem_op(1'b1, 3'b011, 0, 0, 3, 64'h20);
      sb_push("sd_addr", 64'h20); sb_push("sd_be", 64'hFF);
      sb_push("sd_wdata", 64'h8000_0000_0000_0001);
      mem_access(2, 64'h0, 1'b1, 1'b0);

      mem_op(1'b0, 3'b011, 4, 0, 0, 64'h20);
      sb_push("ld_addr", 64'h20); sb_push("ld_be", 64'hFF);
      sb_push("ld_data", 64'h8000_0000_0000_0001);
      mem_access(1, last_wdata, 1'b0, 1'b0);
      sb_pop(get_reg(4));

      mem_op(1'b1, 3'b000, 0, 0, 3, 64'h25);
      sb_push("sb_addr", 64'h25); sb_push("sb_be", 64'h20);
      sb_push("sb_wdata", 64'h0101_0101_0101_0101);
      mem_access(0, 64'h0, 1'b1, 1'b0);

      mem_op(1'b0, 3'b000, 8, 0, 0, 64'h27);
      sb_push("lb7_addr", 64'h27); sb_push("lb7_be", 64'h80);
      sb_push("lb7_data", 64'hFFFF_FFFF_FFFF_FF80);
      mem_access(1, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
      sb_pop(get_reg(8));

      mem_op(1'b0, 3'b111, 9, 0, 0, 64'h20);
      pc0 = pc_now();
      #1 check_eq("ill_stall", 64'(o_stall), 64'd0);
      tick();
      check_eq("ill_req", 64'(o_req), 64'd0);
      check_eq("ill_mis", 64'(o_mis), 64'd1);
      check_eq("ill_pc", pc_now(), pc0 + 64'd4);

      mem_op(1'b0, 3'b011, 7, 0, 0, 64'h20);
      tick();
      tick();
      check_eq("abort_wait_req", 64'(o_req), 64'd1);
      reset = 1'b1;
      tick();
      check_eq("abort_req", 64'(o_req), 64'd0);
      check_eq("abort_pc", pc_now(), RST64);
      check_eq("abort_mis", 64'(o_mis), 64'd0);
      ack = 1'b1;
      rdata = 64'h55;
      tick();
      ack = 1'b0;
      reset = 1'b0;
      idle();
      tick();
      check_eq("abort_no_wr", get_reg(7), 64'd0);
      check_eq("abort_pc_run", pc_now(), RST64 + 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
